fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 16-bit x 8-deep synchronous FIFO among NUM_REQ requesters.
- Throttles grants from the FIFO's full/almostfull flags so that a correct FIFO never overflows.
- Registers the write towards the FIFO.
- Routes the FIFO's wr_ack/overflow response back to the requester that issued the write.
- Sits between producer blocks and the FIFO write side, in the same clock domain.

Parameters:
- FIFO_WIDTH, 16, data width; matches the FIFO.
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), requester index width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester write request; held with its data until granted.
- req_data  input  NUM_REQ*FIFO_WIDTH  packed data; requester i uses slice [i*FIFO_WIDTH +: FIFO_WIDTH].
- gnt  output  NUM_REQ  one-hot-or-zero, combinational; transfer occurs when req[i] & gnt[i].
- done  output  NUM_REQ  one-cycle pulse: the write of requester i was acknowledged (wr_ack).
- drop  output  NUM_REQ  one-cycle pulse: the write of requester i overflowed.
- fifo_wr_en  output  1  registered write enable to the FIFO.
- fifo_data_in  output  FIFO_WIDTH  registered write data to the FIFO.
- fifo_full  input  1  FIFO full flag.
- fifo_almostfull  input  1  FIFO almostfull flag (one entry left).
- fifo_wr_ack  input  1  FIFO write acknowledge, valid the cycle after fifo_wr_en.
- fifo_overflow  input  1  FIFO overflow, valid the cycle after fifo_wr_en.

Behaviour:
- Reset (async assert, sync release): gnt/done/drop = 0, fifo_wr_en = 0, fifo_data_in = 0, rr_ptr = 0, pend_vld = 0, pend_id = 0.
- Reset mid-operation: any in-flight write is abandoned and no done/drop is emitted for it.
- Grant allowed (allow) = !fifo_full && !(fifo_almostfull && fifo_wr_en).
  - fifo_wr_en here is the registered write currently reaching the FIFO.
  - This blocks a second write into the last free slot.
- Arbitration when allow = 1: scan from rr_ptr upward, modulo NUM_REQ.
  - The first set req[i] gets gnt[i] = 1 in the same cycle.
  - rr_ptr <= (i+1) mod NUM_REQ.
  - No request: gnt = 0 and rr_ptr holds.
- When allow = 0: gnt = 0, rr_ptr holds, and requests wait.
- Write stage: on a grant, at the next edge fifo_wr_en <= 1 and fifo_data_in <= req_data slice i; otherwise fifo_wr_en <= 0 and fifo_data_in holds.
  - Latency from grant to FIFO write: 1 cycle.
  - Throughput: 1 write/cycle while allow stays 1.
- Response tracker: pend_vld/pend_id register the granted index together with fifo_wr_en.
  - The cycle after fifo_wr_en, with pend_vld = 1:
    - fifo_wr_ack = 1 gives a done[pend_id] pulse.
    - fifo_overflow = 1 gives a drop[pend_id] pulse.
    - Neither gives drop[pend_id] (treated as a lost write).
  - done/drop are registered: they appear 2 cycles after gnt.
- Back-to-back writes: pend_vld/pend_id are overwritten each cycle. This is correct because the response arrives exactly 1 cycle after each write.
- fifo_wr_ack or fifo_overflow while pend_vld = 0 is ignored.
- Wrap-around: after the grant at index NUM_REQ-1, rr_ptr returns to 0.
- Single active requester: it gets a grant on every allowed cycle.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined: adds output grant_cnt (NUM_REQ*16 bits) and output drop_cnt (16 bits).
  - grant_cnt holds saturating per-requester grant counters.
  - drop_cnt is a saturating count of drop pulses.
  - Both reset to 0 and saturate at 16'hFFFF.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - FIFO_WIDTH_DEF = 16, FIFO_DEPTH_DEF = 8, NUM_REQ_DEF = 4.
  - typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t.
  - typedef enum {RESP_NONE, RESP_ACK, RESP_DROP} resp_e, used by the tracker and the scoreboard.
- Sub-module rr_arbiter (combinational: req, rr_ptr -> one-hot gnt, winner index).
  - rr_ptr is held in fifo_wr_arbiter.
  - The arbiter is reusable on the FIFO read side.

Test Plan:
- Reset mid-write: assert rst_n = 0 while fifo_wr_en = 1 -> all outputs 0 immediately; no done/drop after release; the first grant after release goes to req[0].
- Round-robin: req = 4'b1111 held, FIFO never full -> gnt sequence 0001, 0010, 0100, 1000, 0001; fifo_data_in follows the matching slices one cycle later.
- Fill to full: 5 back-to-back writes into a FIFO holding 3 entries.
  - Gnt stops the cycle fifo_almostfull and fifo_wr_en are both 1.
  - The FIFO reaches 8 entries with fifo_overflow never asserted.
  - 5 done pulses total.
- Overflow attribution: force fifo_overflow = 1 one cycle after the write granted to requester 2 -> drop = 4'b0100 for one cycle, done = 0.
- Lost ack: write granted to requester 1, FIFO returns neither wr_ack nor overflow -> drop[1] pulses once.
- FIFO_WR_ARB_STATS_EN: 10 grants to requester 3 plus 2 forced overflows -> grant_cnt[3] = 10, drop_cnt = 2; without the macro, the build has no such ports.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter and its bench.
package fifo_arb_pkg;

   localparam int FIFO_WIDTH_DEF = 16;
   localparam int FIFO_DEPTH_DEF = 8;
   localparam int NUM_REQ_DEF    = 4;

   typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t;

   typedef enum logic [1:0] {RESP_NONE, RESP_ACK, RESP_DROP} resp_e;

   // A write that is neither acknowledged nor overflowed is counted as lost.
   function automatic resp_e resp_of(input logic vld, input logic ack, input logic ovf);
      if (!vld) return RESP_NONE;
      if (ovf)  return RESP_DROP;
      if (ack)  return RESP_ACK;
      return RESP_DROP;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   win_idx,
   output logic               any_req
);

   logic [IDX_W-1:0] j;

   always_comb begin
      gnt     = '0;
      win_idx = '0;
      any_req = 1'b0;
      j       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         j = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!any_req && req[j]) begin
            gnt[j]  = 1'b1;
            win_idx = j;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port, with full-flag throttling and response routing.
// Optional FIFO_WR_ARB_STATS_EN adds saturating grant_cnt / drop_cnt outputs.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter  int NUM_REQ    = NUM_REQ_DEF,
   localparam int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            done,
   output logic [NUM_REQ-1:0]            drop,
   output logic                          fifo_wr_en,
   output logic [FIFO_WIDTH-1:0]         fifo_data_in,
   input  logic                          fifo_full,
   input  logic                          fifo_almostfull,
   input  logic                          fifo_wr_ack,
   input  logic                          fifo_overflow
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]         grant_cnt,
   output logic [15:0]                   drop_cnt
`endif
);

   logic [IDX_W-1:0]      rr_ptr, win_idx, pend_id;
   logic [NUM_REQ-1:0]    arb_gnt;
   logic                  any_req, allow, grant, pend_vld;
   logic [FIFO_WIDTH-1:0] win_data;
   resp_e                 resp;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .gnt     (arb_gnt),
      .win_idx (win_idx),
      .any_req (any_req)
   );

   // A write already in flight may take the last free slot, so almostfull blocks a second one.
   assign allow = rst_n && !fifo_full && !(fifo_almostfull && fifo_wr_en);
   assign grant = allow && any_req;
   assign gnt   = grant ? arb_gnt : '0;
   assign resp  = resp_of(pend_vld, fifo_wr_ack, fifo_overflow);

   always_comb begin
      win_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         if (win_idx == IDX_W'(i)) win_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_data_in <= '0;
         pend_vld     <= 1'b0;
         pend_id      <= '0;
         done         <= '0;
         drop         <= '0;
      end else begin
         fifo_wr_en <= grant;
         pend_vld   <= grant;
         if (grant) begin
            fifo_data_in <= win_data;
            pend_id      <= win_idx;
            rr_ptr       <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
         end
         // The response always belongs to the previous cycle's write, so one pending slot suffices.
         done <= '0;
         drop <= '0;
         if (resp == RESP_ACK)  done[pend_id] <= 1'b1;
         if (resp == RESP_DROP) drop[pend_id] <= 1'b1;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++)
            if (grant && win_idx == IDX_W'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
               grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
         if (resp == RESP_DROP && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int N = NUM_REQ_DEF;
   localparam int W = FIFO_WIDTH_DEF;
   localparam int D = FIFO_DEPTH_DEF;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req, gnt, done, drop;
   logic [N*W-1:0] req_data;
   logic           fifo_wr_en;
   fifo_word_t     fifo_data_in;
   logic           fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [N*16-1:0] grant_cnt;
   logic [15:0]     drop_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // FIFO environment
   int fcnt = 0;
   bit force_ovf = 0, no_resp = 0, rnd_pop = 0;

   // reference model state
   int           m_ptr, m_id;
   bit           m_wr;
   fifo_word_t   m_data;
   logic [N-1:0] m_done, m_drop;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req             (req),
      .req_data        (req_data),
      .gnt             (gnt),
      .done            (done),
      .drop            (drop),
      .fifo_wr_en      (fifo_wr_en),
      .fifo_data_in    (fifo_data_in),
      .fifo_full       (fifo_full),
      .fifo_almostfull (fifo_almostfull),
      .fifo_wr_ack     (fifo_wr_ack),
      .fifo_overflow   (fifo_overflow)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .grant_cnt       (grant_cnt),
      .drop_cnt        (drop_cnt)
`endif
   );

   task automatic set_flags();
      fifo_full       = (fcnt >= D);
      fifo_almostfull = (fcnt == D-1);
      fifo_overflow   = fifo_wr_en && !no_resp && (force_ovf || fcnt >= D);
      fifo_wr_ack     = fifo_wr_en && !no_resp && !fifo_overflow;
   endtask

   task automatic tick();
      bit stored;
      stored = fifo_wr_en && fifo_wr_ack;
      @(posedge clk);
      if (stored) fcnt++;
      if (rnd_pop && fcnt > 0 && $urandom_range(0, 2) == 0) fcnt--;
      #1;
      set_flags();
   endtask

   task automatic model_reset();
      m_ptr = 0; m_id = 0; m_wr = 0; m_data = '0; m_done = '0; m_drop = '0;
   endtask

   function automatic logic [N-1:0] exp_gnt();
      logic [N-1:0] e;
      e = '0;
      if (!rst_n || fifo_full || (fifo_almostfull && m_wr)) return e;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (req[j]) begin
            e[j] = 1'b1;
            return e;
         end
      end
      return e;
   endfunction

   // Advance the model across one clock edge using this cycle's inputs.
   task automatic model_edge();
      logic [N-1:0] e;
      e = exp_gnt();
      m_done = '0;
      m_drop = '0;
      if (m_wr) begin
         if (fifo_wr_ack && !fifo_overflow) m_done[m_id] = 1'b1;
         else                               m_drop[m_id] = 1'b1;
      end
      m_wr = (e != '0);
      for (int j = 0; j < N; j++)
         if (e[j]) begin
            m_id   = j;
            m_data = req_data[j*W +: W];
            m_ptr  = (j + 1) % N;
         end
   endtask

   task automatic do_reset();
      req = '0; force_ovf = 0; no_resp = 0; rnd_pop = 0; fcnt = 0;
      rst_n = 1'b0;
      #1;
      set_flags();
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
      set_flags();
   endtask

   task automatic test_reset();
      req = '1;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
      rst_n = 1'b0;
      #2;
      set_flags();
      model_reset();
      n_tests++;
      if ({gnt, done, drop, fifo_wr_en, fifo_data_in} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0", {gnt, done, drop, fifo_wr_en, fifo_data_in});
      end
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_first_gnt: got %b required 0001", gnt);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_g;
      fifo_word_t   exp_d;
      do_reset();
      req = '1;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
      for (int c = 0; c < 5; c++) begin
         #1;
         exp_g = '0;
         exp_g[c % N] = 1'b1;
         exp_d = (c == 0) ? '0 : req_data[((c-1) % N)*W +: W];
         n_tests++;
         if ({gnt, fifo_wr_en, fifo_data_in} !== {exp_g, (c != 0), exp_d}) begin
            n_fail++;
            $display("FAIL round_robin c%0d: got gnt=%b wr=%b d=%h required gnt=%b wr=%b d=%h",
                     c, gnt, fifo_wr_en, fifo_data_in, exp_g, (c != 0), exp_d);
         end
         tick();
      end
   endtask

   task automatic test_fill_full();
      int ngnt, ndone;
      bit ovf_seen;
      ngnt = 0; ndone = 0; ovf_seen = 0;
      do_reset();
      fcnt = 3;
      set_flags();
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
      for (int c = 0; c < 10; c++) begin
         req = (c <= 6) ? 4'b1111 : 4'b0000;
         #1;
         if (gnt != '0) ngnt++;
         ndone += $countones(done);
         if (fifo_overflow) ovf_seen = 1;
         n_tests++;
         if ({gnt, done, drop, fifo_wr_en, fifo_data_in} !== {exp_gnt(), m_done, m_drop, m_wr, m_data}) begin
            n_fail++;
            $display("FAIL fill_cycle c%0d: got gnt=%b done=%b drop=%b wr=%b required gnt=%b done=%b drop=%b wr=%b",
                     c, gnt, done, drop, fifo_wr_en, exp_gnt(), m_done, m_drop, m_wr);
         end
         if (c == 5) begin
            n_tests++;
            if (gnt !== 4'b0000 || !(fifo_almostfull && fifo_wr_en)) begin
               n_fail++;
               $display("FAIL fill_stop: got gnt=%b af=%b wr=%b required gnt=0000 af=1 wr=1",
                        gnt, fifo_almostfull, fifo_wr_en);
            end
         end
         model_edge();
         tick();
      end
      n_tests++;
      if (ngnt != 5 || ndone != 5 || fcnt != D || ovf_seen) begin
         n_fail++;
         $display("FAIL fill_totals: got grants=%0d done=%0d level=%0d ovf=%0d required 5 5 %0d 0",
                  ngnt, ndone, fcnt, ovf_seen, D);
      end
   endtask

   task automatic test_overflow_attr();
      do_reset();
      req = 4'b0100;
      req_data = {N*W{1'b0}};
      req_data[2*W +: W] = W'($urandom);
      #1;
      n_tests++;
      if (gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL ovf_gnt: got %b required 0100", gnt);
      end
      force_ovf = 1;
      tick();
      req = '0;
      n_tests++;
      if ({fifo_wr_en, fifo_data_in, fifo_overflow} !== {1'b1, req_data[2*W +: W], 1'b1}) begin
         n_fail++;
         $display("FAIL ovf_write: got wr=%b d=%h ovf=%b required wr=1 d=%h ovf=1",
                  fifo_wr_en, fifo_data_in, fifo_overflow, req_data[2*W +: W]);
      end
      tick();
      force_ovf = 0;
      set_flags();
      n_tests++;
      if ({done, drop} !== {4'b0000, 4'b0100}) begin
         n_fail++;
         $display("FAIL ovf_attr: got done=%b drop=%b required done=0000 drop=0100", done, drop);
      end
      tick();
      n_tests++;
      if ({done, drop} !== 8'h00) begin
         n_fail++;
         $display("FAIL ovf_pulse_len: got done=%b drop=%b required 0000 0000", done, drop);
      end
   endtask

   task automatic test_lost_ack();
      do_reset();
      req = 4'b0010;
      req_data[W +: W] = W'($urandom);
      #1;
      n_tests++;
      if (gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL lost_gnt: got %b required 0010", gnt);
      end
      no_resp = 1;
      tick();
      req = '0;
      tick();
      no_resp = 0;
      set_flags();
      n_tests++;
      if ({done, drop} !== {4'b0000, 4'b0010}) begin
         n_fail++;
         $display("FAIL lost_ack: got done=%b drop=%b required done=0000 drop=0010", done, drop);
      end
      tick();
      n_tests++;
      if (drop !== 4'b0000) begin
         n_fail++;
         $display("FAIL lost_pulse_len: got drop=%b required 0000", drop);
      end
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      req = '1;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
      model_edge();
      tick();
      n_tests++;
      if (fifo_wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_inflight: got wr=%b required 1", fifo_wr_en);
      end
      #2;
      rst_n = 1'b0;
      #1;
      set_flags();
      model_reset();
      n_tests++;
      if ({gnt, done, drop, fifo_wr_en, fifo_data_in} !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got %h required 0", {gnt, done, drop, fifo_wr_en, fifo_data_in});
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_tests++;
         if ({gnt, done, drop, fifo_wr_en, fifo_data_in} !== {exp_gnt(), m_done, m_drop, m_wr, m_data}) begin
            n_fail++;
            $display("FAIL midrst_after c%0d: got gnt=%b done=%b drop=%b required gnt=%b done=%b drop=%b",
                     c, gnt, done, drop, exp_gnt(), m_done, m_drop);
         end
         if (c < 2) begin
            n_tests++;
            if ({done, drop} !== 8'h00 || (c == 0 && gnt !== 4'b0001)) begin
               n_fail++;
               $display("FAIL midrst_quiet c%0d: got gnt=%b done=%b drop=%b required done=drop=0000",
                        c, gnt, done, drop);
            end
         end
         model_edge();
         tick();
      end
   endtask

   task automatic test_random();
      logic [N-1:0] pend, e;
      pend = '0;
      do_reset();
      rnd_pop = 1;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               req_data[i*W +: W] = W'($urandom);
            end
         req = pend;
         #1;
         e = exp_gnt();
         n_tests++;
         if ({gnt, done, drop, fifo_wr_en, fifo_data_in} !== {e, m_done, m_drop, m_wr, m_data}) begin
            n_fail++;
            $display("FAIL random c%0d: got gnt=%b done=%b drop=%b wr=%b d=%h required gnt=%b done=%b drop=%b wr=%b d=%h",
                     c, gnt, done, drop, fifo_wr_en, fifo_data_in, e, m_done, m_drop, m_wr, m_data);
         end
         model_edge();
         pend &= ~e;
         force_ovf = ($urandom_range(0, 15) == 0);
         no_resp   = !force_ovf && ($urandom_range(0, 15) == 0);
         tick();
      end
      rnd_pop = 0;
   endtask

`ifdef FIFO_WR_ARB_STATS_EN
   task automatic test_stats();
      int ng;
      ng = 0;
      do_reset();
      req = 4'b1000;
      req_data[3*W +: W] = W'($urandom);
      for (int c = 0; c < 40 && ng < 10; c++) begin
         #1;
         if (gnt == 4'b1000) ng++;
         force_ovf = gnt[3] && (ng == 3 || ng == 7);
         tick();
         fcnt = 0;
         set_flags();
      end
      req = '0;
      force_ovf = 0;
      tick();
      tick();
      tick();
      n_tests++;
      if (grant_cnt !== {16'd10, 16'd0, 16'd0, 16'd0} || drop_cnt !== 16'd2 || ng != 10) begin
         n_fail++;
         $display("FAIL stats: got grant_cnt=%h drop_cnt=%0d grants=%0d required grant_cnt[3]=10 others 0 drop_cnt=2",
                  grant_cnt, drop_cnt, ng);
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      req = '0;
      req_data = '0;
      test_reset();
      test_round_robin();
      test_fill_full();
      test_overflow_attr();
      test_lost_ack();
      test_reset_mid_write();
      test_random();
`ifdef FIFO_WR_ARB_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
